// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO unit: operation codes and decode helpers.
// Imported by the top level and any unit that decodes HI/LO operations.
package hilo_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    HILO_NONE = 3'd0,
    HILO_MULT = 3'd1,
    HILO_DIV  = 3'd2,
    HILO_MTHI = 3'd3,
    HILO_MTLO = 3'd4,
    HILO_MFHI = 3'd5,
    HILO_MFLO = 3'd6
  } hilo_op_e;

  function automatic logic is_mf(input logic [OP_W-1:0] op);
    return (op == HILO_MFHI) || (op == HILO_MFLO);
  endfunction

endpackage

// File: rtl/hilo_stage_reg.sv
// One HI/LO pipeline register (valid, write enables, data) with stall hold
// and a kill input that loads an empty slot instead of the incoming write.
module hilo_stage_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             kill,
  input  logic             d_valid,
  input  logic             d_we_hi,
  input  logic             d_we_lo,
  input  logic [WIDTH-1:0] d_hi,
  input  logic [WIDTH-1:0] d_lo,
  output logic             q_valid,
  output logic             q_we_hi,
  output logic             q_we_lo,
  output logic [WIDTH-1:0] q_hi,
  output logic [WIDTH-1:0] q_lo
);

  // Stage register: hold on stall, empty slot on kill, otherwise load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_we_hi <= 1'b0;
      q_we_lo <= 1'b0;
      q_hi    <= {WIDTH{1'b0}};
      q_lo    <= {WIDTH{1'b0}};
    end else if (stall) begin
      q_valid <= q_valid;
      q_we_hi <= q_we_hi;
      q_we_lo <= q_we_lo;
      q_hi    <= q_hi;
      q_lo    <= q_lo;
    end else if (kill) begin
      q_valid <= 1'b0;
      q_we_hi <= 1'b0;
      q_we_lo <= 1'b0;
      q_hi    <= d_hi;
      q_lo    <= d_lo;
    end else begin
      q_valid <= d_valid;
      q_we_hi <= d_we_hi;
      q_we_lo <= d_we_lo;
      q_hi    <= d_hi;
      q_lo    <= d_lo;
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit: EX write decode, EX/MEM and MEM/WB stages, commit, and mfhi/mflo reads.
// Define HILO_FWD_EN to forward in-flight writes to reads; otherwise reads raise hazard.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_HI = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] RESET_LO = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [OP_W-1:0]  ex_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic [WIDTH-1:0] alu_r2,
  input  logic [WIDTH-1:0] rs_data,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             hazard,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             ex_we_hi_s, ex_we_lo_s, ex_issue_s;
  logic [WIDTH-1:0] ex_hi_d_s, ex_lo_d_s;
  logic             m_valid_s, m_we_hi_s, m_we_lo_s;
  logic [WIDTH-1:0] m_hi_d_s, m_lo_d_s;
  logic             w_valid_s, w_we_hi_s, w_we_lo_s;
  logic [WIDTH-1:0] w_hi_d_s, w_lo_d_s;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic [WIDTH-1:0] rd_hi_s, rd_lo_s;

  assign ex_issue_s = ex_valid && !flush;

  // Write decode: which halves the EX op writes and with what data.
  always_comb begin
    ex_we_hi_s = 1'b0;
    ex_we_lo_s = 1'b0;
    ex_hi_d_s  = alu_r2;
    ex_lo_d_s  = alu_r;
    case (ex_op)
      HILO_MULT, HILO_DIV: begin
        ex_we_hi_s = ex_issue_s;
        ex_we_lo_s = ex_issue_s;
      end
      HILO_MTHI: begin
        ex_we_hi_s = ex_issue_s;
        ex_hi_d_s  = rs_data;
      end
      HILO_MTLO: begin
        ex_we_lo_s = ex_issue_s;
        ex_lo_d_s  = rs_data;
      end
      default: begin
        ex_we_hi_s = 1'b0;
        ex_we_lo_s = 1'b0;
      end
    endcase
  end

  hilo_stage_reg #(.WIDTH(WIDTH)) u_exmem (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .kill    (flush),
    .d_valid (ex_we_hi_s || ex_we_lo_s),
    .d_we_hi (ex_we_hi_s),
    .d_we_lo (ex_we_lo_s),
    .d_hi    (ex_hi_d_s),
    .d_lo    (ex_lo_d_s),
    .q_valid (m_valid_s),
    .q_we_hi (m_we_hi_s),
    .q_we_lo (m_we_lo_s),
    .q_hi    (m_hi_d_s),
    .q_lo    (m_lo_d_s)
  );

  hilo_stage_reg #(.WIDTH(WIDTH)) u_memwb (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .kill    (1'b0),
    .d_valid (m_valid_s),
    .d_we_hi (m_we_hi_s),
    .d_we_lo (m_we_lo_s),
    .d_hi    (m_hi_d_s),
    .d_lo    (m_lo_d_s),
    .q_valid (w_valid_s),
    .q_we_hi (w_we_hi_s),
    .q_we_lo (w_we_lo_s),
    .q_hi    (w_hi_d_s),
    .q_lo    (w_lo_d_s)
  );

  // Architectural commit of the write leaving MEM/WB, per enabled half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= RESET_HI;
      lo_r <= RESET_LO;
    end else if (!stall && w_valid_s) begin
      hi_r <= w_we_hi_s ? w_hi_d_s : hi_r;
      lo_r <= w_we_lo_s ? w_lo_d_s : lo_r;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  assign hi = hi_r;
  assign lo = lo_r;

`ifdef HILO_FWD_EN
  // Per-half source select: youngest in-flight write first, then the register.
  always_comb begin
    rd_hi_s = hi_r;
    rd_lo_s = lo_r;
    if (m_valid_s && m_we_hi_s) begin
      rd_hi_s = m_hi_d_s;
    end else if (w_valid_s && w_we_hi_s) begin
      rd_hi_s = w_hi_d_s;
    end else begin
      rd_hi_s = hi_r;
    end
    if (m_valid_s && m_we_lo_s) begin
      rd_lo_s = m_lo_d_s;
    end else if (w_valid_s && w_we_lo_s) begin
      rd_lo_s = w_lo_d_s;
    end else begin
      rd_lo_s = lo_r;
    end
  end

  assign hazard = 1'b0;
`else
  assign rd_hi_s = hi_r;
  assign rd_lo_s = lo_r;

  // Block a read while any in-flight write targets the half it reads.
  always_comb begin
    hazard = 1'b0;
    if (ex_valid && (ex_op == HILO_MFHI)) begin
      hazard = (m_valid_s && m_we_hi_s) || (w_valid_s && w_we_hi_s);
    end else if (ex_valid && (ex_op == HILO_MFLO)) begin
      hazard = (m_valid_s && m_we_lo_s) || (w_valid_s && w_we_lo_s);
    end else begin
      hazard = 1'b0;
    end
  end
`endif

  // Read result: zero unless a valid MF* op is in EX.
  always_comb begin
    rdata = {WIDTH{1'b0}};
    if (ex_valid && is_mf(ex_op)) begin
      rdata = (ex_op == HILO_MFHI) ? rd_hi_s : rd_lo_s;
    end else begin
      rdata = {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed scenarios then randomized ops,
// compared against a queue-based model of pending HI/LO writes.
module tb_hilo_unit;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_MULT = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;
  localparam logic [2:0] OP_MFHI = 3'd5;
  localparam logic [2:0] OP_MFLO = 3'd6;

  logic        clk, rst, ex_valid, stall, flush, hazard;
  logic [2:0]  ex_op;
  logic [31:0] alu_r, alu_r2, rs_data, rdata, hi, lo;

  int checks = 0;
  int errors = 0;

  hilo_unit #(.WIDTH(32), .RESET_HI(32'h0), .RESET_LO(32'h0)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op),
    .alu_r(alu_r), .alu_r2(alu_r2), .rs_data(rs_data),
    .stall(stall), .flush(flush), .rdata(rdata), .hazard(hazard),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model: architectural values plus writes still in flight, oldest first.
  typedef struct {
    bit          we_hi;
    bit          we_lo;
    logic [31:0] hv;
    logic [31:0] lv;
    int          age;
  } wr_t;

  wr_t         pend[$];
  logic [31:0] mdl_hi, mdl_lo;

  task automatic model_reset();
    pend.delete();
    mdl_hi = 32'h0;
    mdl_lo = 32'h0;
  endtask

  // One clock edge: each pending write ages; after three edges it lands.
  task automatic model_edge();
    wr_t nw;
    if (!stall) begin
      foreach (pend[i]) pend[i].age++;
      while (pend.size() > 0 && pend[0].age >= 3) begin
        nw = pend.pop_front();
        if (nw.we_hi) mdl_hi = nw.hv;
        if (nw.we_lo) mdl_lo = nw.lv;
      end
      if (ex_valid && !flush) begin
        nw.age = 1;
        nw.we_hi = (ex_op == OP_MULT) || (ex_op == OP_DIV) || (ex_op == OP_MTHI);
        nw.we_lo = (ex_op == OP_MULT) || (ex_op == OP_DIV) || (ex_op == OP_MTLO);
        nw.hv = (ex_op == OP_MTHI) ? rs_data : alu_r2;
        nw.lv = (ex_op == OP_MTLO) ? rs_data : alu_r;
        if (nw.we_hi || nw.we_lo) pend.push_back(nw);
      end
    end
  endtask

  function automatic logic [31:0] exp_rdata();
    logic [31:0] v;
    bit rd_hi;
    if (!ex_valid || !((ex_op == OP_MFHI) || (ex_op == OP_MFLO))) return 32'h0;
    rd_hi = (ex_op == OP_MFHI);
    v = rd_hi ? mdl_hi : mdl_lo;
`ifdef HILO_FWD_EN
    foreach (pend[i]) begin
      if (rd_hi && pend[i].we_hi) v = pend[i].hv;
      if (!rd_hi && pend[i].we_lo) v = pend[i].lv;
    end
`endif
    return v;
  endfunction

  function automatic logic exp_hazard();
    logic h;
    h = 1'b0;
`ifndef HILO_FWD_EN
    if (ex_valid) begin
      foreach (pend[i]) begin
        if (ex_op == OP_MFHI && pend[i].we_hi) h = 1'b1;
        if (ex_op == OP_MFLO && pend[i].we_lo) h = 1'b1;
      end
    end
`endif
    return h;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: check combinational read outputs, clock, then check HI/LO.
  task automatic cyc(input string tag);
    #1;
    chk({tag, "_rdata"}, rdata, exp_rdata());
    chk({tag, "_hazard"}, {31'b0, hazard}, {31'b0, exp_hazard()});
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_hi"}, hi, mdl_hi);
    chk({tag, "_lo"}, lo, mdl_lo);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] r2,
                       input logic [31:0] r, input logic [31:0] rs,
                       input logic st, input logic fl);
    ex_valid = v; ex_op = op; alu_r2 = r2; alu_r = r; rs_data = rs;
    stall = st; flush = fl;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0;
    drive(1'b1, OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    model_reset();

    // Reset asserted mid-cycle takes effect at once.
    #2 rst = 1'b1;
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // MULT commits after three edges; later MFLO reads it.
    drive(1'b1, OP_MULT, 32'h1, 32'hFFFF0000, 32'h0, 1'b0, 1'b0);
    cyc("mult");
    drive(1'b0, OP_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc("mult_w1");
    chk("mult_early_hi", hi, 32'h0);
    cyc("mult_w2");
    chk("mult_hi", hi, 32'h1);
    chk("mult_lo", lo, 32'hFFFF0000);
    drive(1'b1, OP_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc("mflo");
    #1;
    chk("mflo_const", rdata, 32'hFFFF0000);

    // MTHI then immediate MFHI: forwarded, or hazard for two cycles.
    drive(1'b1, OP_MTHI, 32'h0, 32'h0, 32'hA5, 1'b0, 1'b0);
    cyc("mthi");
    drive(1'b1, OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef HILO_FWD_EN
    #1;
    chk("mfhi_fwd_const", rdata, 32'hA5);
    chk("mfhi_fwd_haz", {31'b0, hazard}, 32'h0);
`else
    #1;
    chk("mfhi_haz_const", {31'b0, hazard}, 32'h1);
`endif
    cyc("mfhi_a");
    cyc("mfhi_b");
    #1;
    chk("mfhi_final_const", rdata, 32'hA5);
    chk("mfhi_final_haz", {31'b0, hazard}, 32'h0);
    cyc("mfhi_c");

    // Back-to-back MTLO: later value wins.
    drive(1'b1, OP_MTLO, 32'h0, 32'h0, 32'h11, 1'b0, 1'b0);
    cyc("mtlo1");
    drive(1'b1, OP_MTLO, 32'h0, 32'h0, 32'h22, 1'b0, 1'b0);
    cyc("mtlo2");
    drive(1'b1, OP_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("mtlo_rd");
    chk("mtlo_final", lo, 32'h22);

    // Flushed DIV never commits.
    drive(1'b1, OP_DIV, 32'hDEAD, 32'hBEEF, 32'h0, 1'b0, 1'b1);
    cyc("div_flush");
    drive(1'b0, OP_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("div_after");
    chk("div_hi", hi, 32'hA5);
    chk("div_lo", lo, 32'h22);

    // Three stall cycles delay the MULT commit by exactly three cycles.
    drive(1'b1, OP_MULT, 32'h77, 32'h88, 32'h0, 1'b0, 1'b0);
    cyc("st_issue");
    drive(1'b0, OP_NONE, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("st_hold");
    drive(1'b0, OP_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc("st_run1");
    chk("st_not_yet", hi, 32'hA5);
    cyc("st_run2");
    chk("st_hi", hi, 32'h77);
    chk("st_lo", lo, 32'h88);

    // Stall and flush together hold the MTHI; it enters once released.
    drive(1'b1, OP_MTHI, 32'h0, 32'h0, 32'h5A, 1'b1, 1'b1);
    cyc("sf_both");
    drive(1'b1, OP_MTHI, 32'h0, 32'h0, 32'h5A, 1'b0, 1'b0);
    cyc("sf_go");
    drive(1'b0, OP_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc("sf_w1");
    cyc("sf_w2");
    chk("sf_hi", hi, 32'h5A);

    // Reset mid-flight discards the pending MULT.
    drive(1'b1, OP_MULT, 32'h1234, 32'h5678, 32'h0, 1'b0, 1'b0);
    cyc("rst_mid_issue");
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, OP_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("rst_mid_after");

    // Randomized op stream against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
            3'($urandom_range(0, 6)), $urandom, $urandom, $urandom,
            ($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) < 1) ? 1'b1 : 1'b0);
      cyc("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
